alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares one 32-bit MIPS ALU (6-bit funct-style ALUControl) between two requesters, e.g. the EX stage (port 0) and the branch-compare unit (port 1).
- Per transaction: round-robin arbitration, operand registration, a fixed multi-cycle execute window (longer for MUL), result capture, and a one-cycle response with a locally computed Zero flag.

Parameters:
- MUL_CYCLES, 4, execute cycles for MUL (011000); legal range 1..15.
- OP_CYCLES, 1, execute cycles for every other supported op; legal range 1..15.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- ReqValid0 / ReqValid1  in  1  request valid, per requester.
- ReqReady0 / ReqReady1  out  1  request accepted this cycle.
- ReqCtl0 / ReqCtl1  in  6  ALU opcode.
- ReqA0 / ReqA1  in  32  operand A.
- ReqB0 / ReqB1  in  32  operand B.
- AluControl  out  6  to ALU control input.
- AluA  out  32  to ALU port A.
- AluB  out  32  to ALU port B.
- AluResult  in  32  from ALU (combinational).
- RspValid  out  1  one-cycle response strobe.
- RspId  out  1  requester that owns the response.
- RspResult  out  32  captured result.
- RspZero  out  1  1 iff RspResult == 0.
- RspIllegal  out  1  opcode not supported.

Behaviour:
- Supported opcodes: 100000 add, 100010 sub, 011000 mul, 100100 and, 100101 or, 100111 nor, 100110 xor, 000000 sll, 000010 srl, 101010 slt. Anything else is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - ReqReadyN = (state==IDLE) & grantN; combinational; at most one ready at a time.
  - On accept: latch Ctl/A/B/Id into operand registers, load the counter with L (MUL_CYCLES for MUL, OP_CYCLES otherwise), go to EXEC.
- EXEC:
  - AluControl/AluA/AluB driven from the operand registers; they are held constant for the whole window.
  - Counter decrements each cycle. In the cycle where the counter equals 1, AluResult is captured into RspResult and the FSM goes to RESP.
- RESP:
  - RspValid=1 for exactly one cycle with RspId, RspResult, RspZero, RspIllegal valid. Then IDLE.
  - No accept occurs in RESP.
- Latency: request accepted at the edge ending cycle T; RspValid is high in cycle T+L+1. Next accept is possible no earlier than cycle T+L+2.
- Illegal opcode:
  - Accepted normally with L = OP_CYCLES.
  - AluControl is driven as 100000 with A=B=0.
  - RspResult=0, RspZero=1, RspIllegal=1.
- Arbitration:
  - Round-robin pointer `last` holds the last-granted id; reset value is 1, so port 0 wins first.
  - Both valid: grant !last.
  - One valid: grant that one.
  - `last` updates only on accept.
- Requester obligations:
  - ReqValid must not depend on ReqReady.
  - Ctl/A/B are sampled only at the accept edge; later changes are ignored.
  - An ungranted requester keeps ReqValid high and is served later; its request is not dropped.
- Outputs when not in RESP: RspValid=0. RspResult, RspId, RspZero and RspIllegal hold their last values.
- Reset (Reset==0 at an edge), including mid-EXEC or in RESP:
  - state=IDLE, counter=0, last=1.
  - Operand registers=0, so AluControl=000000, AluA=0, AluB=0.
  - RspValid=0, RspId=0, RspResult=0, RspZero=1, RspIllegal=0.
  - An aborted transaction produces no response.
- Width rules:
  - The result is whatever the ALU returns, truncated to 32 bits (MUL keeps the low 32 bits).
  - The controller does not recompute results; it computes only RspZero.

Test Plan:
- Reset then single add: port0 add A=5,B=7 accepted at T -> RspValid at T+2, RspId=0, RspResult=12, RspZero=0; ReqReady low in EXEC/RESP.
- MUL latency: port1 mul A=0x00010000,B=0x00010000, MUL_CYCLES=4 -> RspValid exactly at T+5, RspResult=0, RspZero=1, RspIllegal=0; AluA/AluB stable across all 4 EXEC cycles.
- Round-robin under contention: both ports hold valid continuously with sub 9-9 / or 1|2 -> grants alternate 0,1,0,1. Responses are 0/RspZero=1 for port 0 and 3/RspZero=0 for port 1, with no starvation over 8 transactions.
- Illegal op: port0 ReqCtl=101000 -> one-cycle execute, RspIllegal=1, RspResult=0, RspZero=1, AluControl=100000 during EXEC.
- Reset mid-op: assert Reset low during the 2nd EXEC cycle of a MUL -> next cycle IDLE, no RspValid ever for that op, all outputs at reset values. Port0 is granted first after release even if both ports are valid.
- Operand change after accept: port0 changes ReqA after accept -> RspResult reflects the originally sampled A.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one 32-bit ALU between two requesters.
// Round-robin grant, operand capture, fixed execute window, one-cycle response.
module alu_share_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int OP_CYCLES  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid0,
  input  logic        ReqValid1,
  output logic        ReqReady0,
  output logic        ReqReady1,
  input  logic [5:0]  ReqCtl0,
  input  logic [5:0]  ReqCtl1,
  input  logic [31:0] ReqA0,
  input  logic [31:0] ReqA1,
  input  logic [31:0] ReqB0,
  input  logic [31:0] ReqB1,
  output logic [5:0]  AluControl,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  input  logic [31:0] AluResult,
  output logic        RspValid,
  output logic        RspId,
  output logic [31:0] RspResult,
  output logic        RspZero,
  output logic        RspIllegal
);

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_MUL = 6'b011000;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SLT = 6'b101010;

  localparam logic [3:0] LEN_MUL = 4'(MUL_CYCLES);
  localparam logic [3:0] LEN_OP  = 4'(OP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state;
  state_t      nxt;

  logic        last;
  logic [3:0]  cnt;
  logic [5:0]  op_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_id;
  logic        op_ill;

  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_ill;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [5:0]  sel_ctl;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_legal;
  logic [3:0]  sel_len;
  logic        last_cycle;

  // Round-robin grant: on contention the port not granted last time wins.
  always_comb begin
    grant0    = ReqValid0 & (~ReqValid1 | last);
    grant1    = ReqValid1 & (~ReqValid0 | ~last);
    ReqReady0 = (state == IDLE) & grant0;
    ReqReady1 = (state == IDLE) & grant1;
    accept    = ReqReady0 | ReqReady1;
  end

  // Pick the granted request and classify its opcode.
  always_comb begin
    sel_ctl   = grant1 ? ReqCtl1 : ReqCtl0;
    sel_a     = grant1 ? ReqA1   : ReqA0;
    sel_b     = grant1 ? ReqB1   : ReqB0;
    sel_legal = 1'b0;
    sel_len   = LEN_OP;
    unique case (sel_ctl)
      OP_MUL: begin
        sel_legal = 1'b1;
        sel_len   = LEN_MUL;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
      OP_XOR, OP_SLL, OP_SRL, OP_SLT:
        sel_legal = 1'b1;
      default: sel_legal = 1'b0;
    endcase
  end

  assign last_cycle = (cnt == 4'd1);

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = EXEC;
      EXEC:    if (last_cycle) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand capture, window counter and result capture.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      last       <= 1'b1;
      cnt        <= '0;
      op_ctl     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      op_ill     <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_ill    <= 1'b0;
    end else if (accept) begin
      last   <= grant1;
      cnt    <= sel_len;
      op_id  <= grant1;
      op_ill <= ~sel_legal;
      op_ctl <= sel_legal ? sel_ctl : OP_ADD;
      op_a   <= sel_legal ? sel_a : '0;
      op_b   <= sel_legal ? sel_b : '0;
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
      if (last_cycle) begin
        rsp_id     <= op_id;
        rsp_ill    <= op_ill;
        rsp_result <= op_ill ? '0 : AluResult;
      end
    end
  end

  // ALU drive and response outputs.
  always_comb begin
    AluControl = op_ctl;
    AluA       = op_a;
    AluB       = op_b;
    RspValid   = (state == RESP);
    RspId      = rsp_id;
    RspResult  = rsp_result;
    RspZero    = (rsp_result == '0);
    RspIllegal = rsp_ill;
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of the shared-ALU sequencer.
// A small behavioural ALU sits on the Alu* ports.
module tb_alu_share_ctrl;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] MUL = 6'b011000;
  localparam logic [5:0] OR_ = 6'b100101;
  localparam logic [5:0] BAD = 6'b101000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, r0, r1;
  logic [5:0]  c0, c1;
  logic [31:0] a0, a1, b0, b1;
  logic [5:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        rsp_v, rsp_id, rsp_z, rsp_ill;
  logic [31:0] rsp_res;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.MUL_CYCLES(4), .OP_CYCLES(1)) dut (
    .Clk(clk), .Reset(rst_n),
    .ReqValid0(v0), .ReqValid1(v1),
    .ReqReady0(r0), .ReqReady1(r1),
    .ReqCtl0(c0), .ReqCtl1(c1),
    .ReqA0(a0), .ReqA1(a1),
    .ReqB0(b0), .ReqB1(b1),
    .AluControl(alu_ctl), .AluA(alu_a), .AluB(alu_b),
    .AluResult(alu_res),
    .RspValid(rsp_v), .RspId(rsp_id),
    .RspResult(rsp_res), .RspZero(rsp_z),
    .RspIllegal(rsp_ill)
  );

  always_comb begin
    alu_res = '0;
    case (alu_ctl)
      6'b100000: alu_res = alu_a + alu_b;
      6'b100010: alu_res = alu_a - alu_b;
      6'b011000: alu_res = alu_a * alu_b;
      6'b100100: alu_res = alu_a & alu_b;
      6'b100101: alu_res = alu_a | alu_b;
      6'b100111: alu_res = ~(alu_a | alu_b);
      6'b100110: alu_res = alu_a ^ alu_b;
      6'b000000: alu_res = alu_a << alu_b[4:0];
      6'b000010: alu_res = alu_a >> alu_b[4:0];
      6'b101010: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default:   alu_res = '0;
    endcase
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vecs++;
    if (rsp_v !== 1'b0) begin
      errs++; $display("FAIL rst_valid got=%0h exp=0", rsp_v);
    end
    vecs++;
    if (rsp_res !== 32'd0 || rsp_id !== 1'b0) begin
      errs++; $display("FAIL rst_rsp got=%0h/%0h exp=0/0", rsp_res, rsp_id);
    end
    vecs++;
    if (rsp_z !== 1'b1 || rsp_ill !== 1'b0) begin
      errs++; $display("FAIL rst_flags got z=%0h ill=%0h exp=1/0", rsp_z, rsp_ill);
    end
    vecs++;
    if ({alu_ctl, alu_a, alu_b} !== 70'd0) begin
      errs++; $display("FAIL rst_alu got=%0h/%0h/%0h exp=0", alu_ctl, alu_a, alu_b);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    v0 = 1'b1; c0 = ADD; a0 = 32'd5; b0 = 32'd7;
    #1;
    vecs++;
    if ({r1, r0} !== 2'b01) begin
      errs++; $display("FAIL add_grant got=%b exp=01", {r1, r0});
    end
    step();
    vecs++;
    if (r0 !== 1'b0 || rsp_v !== 1'b0) begin
      errs++; $display("FAIL add_exec got rdy=%0h v=%0h exp=0/0", r0, rsp_v);
    end
    vecs++;
    if (alu_ctl !== ADD || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      errs++; $display("FAIL add_alu got=%0h/%0h/%0h exp=20/5/7", alu_ctl, alu_a, alu_b);
    end
    step();
    vecs++;
    if (rsp_v !== 1'b1 || r0 !== 1'b0) begin
      errs++; $display("FAIL add_resp got v=%0h rdy=%0h exp=1/0", rsp_v, r0);
    end
    vecs++;
    if (rsp_res !== 32'd12 || rsp_id !== 1'b0 || rsp_z !== 1'b0 || rsp_ill !== 1'b0) begin
      errs++; $display("FAIL add_data got=%0d id=%0h z=%0h ill=%0h exp=12/0/0/0", rsp_res, rsp_id, rsp_z, rsp_ill);
    end
    v0 = 1'b0;
    step();
    vecs++;
    if (rsp_v !== 1'b0 || rsp_res !== 32'd12) begin
      errs++; $display("FAIL add_hold got v=%0h res=%0d exp=0/12", rsp_v, rsp_res);
    end
  endtask

  task automatic test_mul();
    v1 = 1'b1; c1 = MUL; a1 = 32'h0001_0000; b1 = 32'h0001_0000;
    #1;
    vecs++;
    if ({r1, r0} !== 2'b10) begin
      errs++; $display("FAIL mul_grant got=%b exp=10", {r1, r0});
    end
    @(negedge clk);
    v1 = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      vecs++;
      if (rsp_v !== 1'b0 || alu_ctl !== MUL || alu_a !== 32'h10000 || alu_b !== 32'h10000) begin
        errs++; $display("FAIL mul_exec%0d got v=%0h %0h/%0h/%0h exp=0 18/10000/10000", k, rsp_v, alu_ctl, alu_a, alu_b);
      end
      step();
    end
    vecs++;
    if (rsp_v !== 1'b1 || rsp_id !== 1'b1) begin
      errs++; $display("FAIL mul_resp got v=%0h id=%0h exp=1/1", rsp_v, rsp_id);
    end
    vecs++;
    if (rsp_res !== 32'd0 || rsp_z !== 1'b1 || rsp_ill !== 1'b0) begin
      errs++; $display("FAIL mul_data got=%0h z=%0h ill=%0h exp=0/1/0", rsp_res, rsp_z, rsp_ill);
    end
    step();
  endtask

  task automatic test_round_robin();
    int n;
    logic exp_id;
    v0 = 1'b1; c0 = SUB; a0 = 32'd9; b0 = 32'd9;
    v1 = 1'b1; c1 = OR_; a1 = 32'd1; b1 = 32'd2;
    #1;
    exp_id = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!(r0 | r1) && n < 10) begin step(); n++; end
      vecs++;
      if ({r1, r0} !== (exp_id ? 2'b10 : 2'b01)) begin
        errs++; $display("FAIL rr_grant%0d got=%b exp_id=%0d", i, {r1, r0}, exp_id);
      end
      step();
      n = 0;
      while (!rsp_v && n < 10) begin step(); n++; end
      vecs++;
      if (rsp_v !== 1'b1 || rsp_id !== exp_id) begin
        errs++; $display("FAIL rr_rsp%0d got v=%0h id=%0h exp=1/%0h", i, rsp_v, rsp_id, exp_id);
      end
      vecs++;
      if (rsp_res !== (exp_id ? 32'd3 : 32'd0) || rsp_z !== ~exp_id) begin
        errs++; $display("FAIL rr_data%0d got=%0d z=%0h exp=%0d/%0h", i, rsp_res, rsp_z, exp_id ? 3 : 0, ~exp_id);
      end
      exp_id = ~exp_id;
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_op();
    int n;
    v0 = 1'b1; c0 = MUL; a0 = 32'd3; b0 = 32'd5;
    #1;
    vecs++;
    if (r0 !== 1'b1) begin
      errs++; $display("FAIL rmid_grant got=%0h exp=1", r0);
    end
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    step();
    vecs++;
    if (rsp_v !== 1'b0 || rsp_id !== 1'b0 || rsp_res !== 32'd0) begin
      errs++; $display("FAIL rmid_rsp got v=%0h id=%0h res=%0d exp=0/0/0", rsp_v, rsp_id, rsp_res);
    end
    vecs++;
    if (rsp_z !== 1'b1 || rsp_ill !== 1'b0 || {alu_ctl, alu_a, alu_b} !== 70'd0) begin
      errs++; $display("FAIL rmid_out got z=%0h ill=%0h alu=%0h/%0h/%0h exp=1/0/0", rsp_z, rsp_ill, alu_ctl, alu_a, alu_b);
    end
    v0 = 1'b1; c0 = ADD; a0 = 32'd5; b0 = 32'd7;
    v1 = 1'b1; c1 = OR_; a1 = 32'd1; b1 = 32'd2;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++;
    if ({r1, r0} !== 2'b01 || rsp_v !== 1'b0) begin
      errs++; $display("FAIL rmid_first got=%b v=%0h exp=01/0", {r1, r0}, rsp_v);
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    #1;
    n = 0;
    while (!rsp_v && n < 10) begin step(); n++; end
    vecs++;
    if (rsp_v !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 32'd12) begin
      errs++; $display("FAIL rmid_after got v=%0h id=%0h res=%0d exp=1/0/12", rsp_v, rsp_id, rsp_res);
    end
    step();
  endtask

  task automatic test_operand_change();
    v0 = 1'b1; c0 = ADD; a0 = 32'd10; b0 = 32'd20;
    #1;
    vecs++;
    if (r0 !== 1'b1) begin
      errs++; $display("FAIL opchg_grant got=%0h exp=1", r0);
    end
    @(negedge clk);
    v0 = 1'b0; a0 = 32'd1000; b0 = 32'd2000;
    #1;
    vecs++;
    if (alu_a !== 32'd10 || alu_b !== 32'd20) begin
      errs++; $display("FAIL opchg_alu got=%0d/%0d exp=10/20", alu_a, alu_b);
    end
    step();
    vecs++;
    if (rsp_v !== 1'b1 || rsp_res !== 32'd30 || rsp_z !== 1'b0) begin
      errs++; $display("FAIL opchg_rsp got v=%0h res=%0d z=%0h exp=1/30/0", rsp_v, rsp_res, rsp_z);
    end
    step();
  endtask

  task automatic test_illegal();
    v0 = 1'b1; c0 = BAD; a0 = 32'd3; b0 = 32'd4;
    #1;
    vecs++;
    if (r0 !== 1'b1) begin
      errs++; $display("FAIL ill_grant got=%0h exp=1", r0);
    end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    vecs++;
    if (alu_ctl !== ADD || alu_a !== 32'd0 || alu_b !== 32'd0 || rsp_v !== 1'b0) begin
      errs++; $display("FAIL ill_exec got=%0h/%0h/%0h v=%0h exp=20/0/0/0", alu_ctl, alu_a, alu_b, rsp_v);
    end
    step();
    vecs++;
    if (rsp_v !== 1'b1 || rsp_ill !== 1'b1 || rsp_id !== 1'b0) begin
      errs++; $display("FAIL ill_resp got v=%0h ill=%0h id=%0h exp=1/1/0", rsp_v, rsp_ill, rsp_id);
    end
    vecs++;
    if (rsp_res !== 32'd0 || rsp_z !== 1'b1) begin
      errs++; $display("FAIL ill_data got=%0h z=%0h exp=0/1", rsp_res, rsp_z);
    end
    step();
    vecs++;
    if (rsp_v !== 1'b0 || rsp_ill !== 1'b1) begin
      errs++; $display("FAIL ill_hold got v=%0h ill=%0h exp=0/1", rsp_v, rsp_ill);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    c0 = '0; c1 = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    test_reset();
    test_add();
    test_mul();
    test_round_robin();
    test_reset_mid_op();
    test_operand_change();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
